i2s_receiver: RTL and testbench
===============================

# i2s_receiver

Serial-to-parallel I2S receiver for the capture path, the counterpart to the DAC I2S transmitter in AudVid. It takes bit clock, word select and data from an external I2S master (ADC/codec) and oversamples them in the MasterCLK domain. It then presents each completed stereo frame as a left/right sample pair with a valid/ready handshake. It sits beside AudVid and is fed from board pins; downstream is a sample FIFO or DSP block.

## Interface
- SAMPLE_WIDTH, 16, bits kept per channel (MSB-first); slot bits beyond this are ignored
- MasterCLK  in  1  sole clock; all logic on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- ADC_I2S_CLK  in  1  external bit clock (BCK), asynchronous to MasterCLK
- ADC_I2S_WS  in  1  word select; 0 = left, 1 = right; asynchronous
- ADC_I2S_DATA  in  1  serial data; asynchronous
- SampleLeft  out  SAMPLE_WIDTH  left sample of the presented pair
- SampleRight  out  SAMPLE_WIDTH  right sample of the presented pair
- SampleValid  out  1  pair presented; held until accepted
- SampleReady  in  1  consumer accepts the pair when SampleValid && SampleReady
- Overrun  out  1  one-cycle pulse: new pair overwrote an unaccepted pair
- FrameError  out  1  one-cycle pulse: slot shorter than SAMPLE_WIDTH bits

## Operation
- Input conditioning:
  - Each of BCK, WS and DATA passes through a 2-FF synchronizer.
  - A third BCK register detects rising edges; one detected edge is called E.
  - On E, the synchronized d (DATA) and w (WS) are used.
- Per E, in this order:
  - If BitCount < SAMPLE_WIDTH: ShiftReg <= {ShiftReg[SAMPLE_WIDTH-2:0], d}. BitCount increments and saturates at SAMPLE_WIDTH.
  - wchg = (w != WsPrev). WsPrev <= w.
  - If wchg: the slot for channel WsPrev ends. Word = ShiftReg value after this edge's shift. BitCount <= 0. The next E carries the new slot's MSB (standard I2S one-bit delay).
- States: UNSYNC, LEFT, RIGHT.
  - UNSYNC: data discarded. A wchg with w = 0 moves to LEFT. A wchg with w = 1 moves to RIGHT but marks the slot as not usable for pairing.
  - LEFT end (wchg to 1):
    - If BitCount before clear < SAMPLE_WIDTH: FrameError pulse and LeftPending <= 0.
    - Otherwise LeftHold <= Word and LeftPending <= 1.
    - Go to RIGHT.
  - RIGHT end (wchg to 0):
    - If short: FrameError pulse, no publish.
    - Else if LeftPending: publish {LeftHold, Word} and clear LeftPending.
    - Go to LEFT.
- Publish:
  - SampleLeft/SampleRight are loaded and SampleValid <= 1.
  - If SampleValid was 1 and SampleReady was 0 in the same cycle, Overrun pulses; the old pair is lost.
  - If ready and publish occur in the same cycle: no overrun, the new pair is loaded, and SampleValid stays 1.
- Handshake: with SampleValid high, SampleReady high and no publish, SampleValid <= 0 on the next edge. Outputs hold their values otherwise.
- A right slot with no preceding complete left slot (start-up, or after an error) is discarded silently.

## Timing
- Reset:
  - SampleLeft = SampleRight = 0; SampleValid = Overrun = FrameError = 0.
  - State UNSYNC; BitCount = 0; WsPrev = 0; synchronizers = 0.
  - A Reset mid-frame drops the partial frame. The first pair after release requires a full left+right slot following a WS falling edge.
- Requirement: BCK high and low phases are each ≥ 2 MasterCLK periods (BCK ≤ MasterCLK/4).
- Latency: from the pin BCK rising edge that carries the right LSB (coincident WS 1→0) to SampleValid high is 4 MasterCLK cycles: 2 sync, 1 edge detect, 1 output register.
- Overrun and FrameError are single-cycle, registered pulses.
- A first right-slot end with no pending left produces no output and no error.

## Test plan
- Reset, then 32-bit slots (SAMPLE_WIDTH = 16), BCK = MasterCLK/8, left 0xA5C3, right 0x1234 -> first full frame gives SampleLeft = 0xA5C3 and SampleRight = 0x1234. SampleValid rises 4 cycles after the closing BCK edge. The start-up partial frame is not published.
- Same stream with SampleReady tied 1 -> one SampleValid cycle per frame, consecutive pairs 0xA5C3/0x1234 then 0x0001/0xFFFF, no Overrun.
- SampleReady held 0 across two frames -> SampleValid stays 1, Overrun pulses once at the second publish, and the outputs show the second pair.
- Left slot truncated to 10 BCKs -> FrameError pulses once, that frame's pair is not published, and the next full frame publishes correctly.
- 16-bit slots (exactly SAMPLE_WIDTH), left 0x8000, right 0x0001 -> MSB/LSB alignment is correct and no FrameError.
- Reset asserted mid-right-slot -> all outputs are 0 immediately (asynchronous); after release, the first valid pair comes from the first complete left+right slot following a WS falling edge.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S capture receiver: oversamples BCK/WS/DATA in the MasterCLK domain and
// presents each complete left/right frame through a valid/ready output register.
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    MasterCLK,
    input  logic                    Reset,
    input  logic                    ADC_I2S_CLK,
    input  logic                    ADC_I2S_WS,
    input  logic                    ADC_I2S_DATA,
    output logic [SAMPLE_WIDTH-1:0] SampleLeft,
    output logic [SAMPLE_WIDTH-1:0] SampleRight,
    output logic                    SampleValid,
    input  logic                    SampleReady,
    output logic                    Overrun,
    output logic                    FrameError
);
    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(SAMPLE_WIDTH);

    typedef enum logic [1:0] {UNSYNC, LEFT, RIGHT} state_t;

    // Pin bundle: [0] = BCK, [1] = WS, [2] = DATA
    logic [2:0] pins;
    logic [2:0] sync1_reg;
    logic [2:0] sync2_reg;
    logic       bck_prev_reg;
    logic       edge_reg;
    logic       d_reg;
    logic       w_reg;

    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] shift_next;
    logic [SAMPLE_WIDTH-1:0] left_hold_reg;
    logic [CW-1:0]           bit_count_reg;
    logic [CW-1:0]           count_inc;
    logic                    ws_prev_reg;
    logic                    pending_reg;
    logic                    pending_next;
    state_t                  state_reg;
    state_t                  state_next;

    logic [SAMPLE_WIDTH-1:0] left_out_reg;
    logic [SAMPLE_WIDTH-1:0] right_out_reg;
    logic                    valid_reg;
    logic                    overrun_reg;
    logic                    frame_error_reg;

    logic wchg;
    logic slot_end;
    logic short_slot;
    logic load_left;
    logic publish;
    logic frame_err;

    assign pins = {ADC_I2S_DATA, ADC_I2S_WS, ADC_I2S_CLK};

    // Edge pulse and its sampled DATA/WS are registered together so they stay aligned.
    always_ff @(posedge MasterCLK or posedge Reset) begin
        if (Reset) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            bck_prev_reg <= 1'b0;
            edge_reg     <= 1'b0;
            d_reg        <= 1'b0;
            w_reg        <= 1'b0;
        end else begin
            sync1_reg    <= pins;
            sync2_reg    <= sync1_reg;
            bck_prev_reg <= sync2_reg[0];
            edge_reg     <= sync2_reg[0] & ~bck_prev_reg;
            d_reg        <= sync2_reg[2];
            w_reg        <= sync2_reg[1];
        end
    end

    always_comb begin
        shift_next = shift_reg;
        count_inc  = bit_count_reg;
        if (bit_count_reg < FULL_COUNT) begin
            shift_next = {shift_reg[SAMPLE_WIDTH-2:0], d_reg};
            count_inc  = bit_count_reg + CW'(1);
        end
    end

    assign wchg       = (w_reg != ws_prev_reg);
    assign slot_end   = edge_reg & wchg;
    assign short_slot = (count_inc < FULL_COUNT);

    always_ff @(posedge MasterCLK or posedge Reset) begin
        if (Reset) begin
            state_reg <= UNSYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        load_left    = 1'b0;
        publish      = 1'b0;
        frame_err    = 1'b0;
        if (slot_end) begin
            case (state_reg)
                UNSYNC: begin
                    // A right slot entered from here has no left partner.
                    state_next   = w_reg ? RIGHT : LEFT;
                    pending_next = 1'b0;
                end
                LEFT: begin
                    state_next = RIGHT;
                    if (short_slot) begin
                        frame_err    = 1'b1;
                        pending_next = 1'b0;
                    end else begin
                        load_left    = 1'b1;
                        pending_next = 1'b1;
                    end
                end
                RIGHT: begin
                    state_next   = LEFT;
                    pending_next = 1'b0;
                    // Orphan right slots are dropped without flagging.
                    if (pending_reg) begin
                        if (short_slot) begin
                            frame_err = 1'b1;
                        end else begin
                            publish = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next   = UNSYNC;
                    pending_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge MasterCLK or posedge Reset) begin
        if (Reset) begin
            shift_reg       <= '0;
            bit_count_reg   <= '0;
            ws_prev_reg     <= 1'b0;
            pending_reg     <= 1'b0;
            left_hold_reg   <= '0;
            left_out_reg    <= '0;
            right_out_reg   <= '0;
            valid_reg       <= 1'b0;
            overrun_reg     <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            pending_reg     <= pending_next;
            frame_error_reg <= frame_err;
            overrun_reg     <= publish & valid_reg & ~SampleReady;
            if (edge_reg) begin
                shift_reg     <= shift_next;
                ws_prev_reg   <= w_reg;
                bit_count_reg <= wchg ? '0 : count_inc;
            end
            if (load_left) begin
                left_hold_reg <= shift_next;
            end
            if (publish) begin
                left_out_reg  <= left_hold_reg;
                right_out_reg <= shift_next;
                valid_reg     <= 1'b1;
            end else if (valid_reg && SampleReady) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign SampleLeft  = left_out_reg;
    assign SampleRight = right_out_reg;
    assign SampleValid = valid_reg;
    assign Overrun     = overrun_reg;
    assign FrameError  = frame_error_reg;

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: slot-level reference model feeds an expected
// pair queue; a monitor pops and compares on every accepted or overwritten pair.
module tb_i2s_receiver;
    logic        MasterCLK = 1'b0;
    logic        Reset = 1'b1;
    logic        ADC_I2S_CLK = 1'b0;
    logic        ADC_I2S_WS = 1'b0;
    logic        ADC_I2S_DATA = 1'b0;
    logic        SampleReady = 1'b0;
    logic [15:0] SampleLeft;
    logic [15:0] SampleRight;
    logic        SampleValid;
    logic        Overrun;
    logic        FrameError;

    i2s_receiver #(.SAMPLE_WIDTH(16)) dut (
        .MasterCLK   (MasterCLK),
        .Reset       (Reset),
        .ADC_I2S_CLK (ADC_I2S_CLK),
        .ADC_I2S_WS  (ADC_I2S_WS),
        .ADC_I2S_DATA(ADC_I2S_DATA),
        .SampleLeft  (SampleLeft),
        .SampleRight (SampleRight),
        .SampleValid (SampleValid),
        .SampleReady (SampleReady),
        .Overrun     (Overrun),
        .FrameError  (FrameError)
    );

    always #5 MasterCLK = ~MasterCLK;

    typedef struct {
        bit          chan;
        int          len;
        logic [31:0] val;
    } slot_t;

    slot_t       slot_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] popped;

    int n_checks = 0;
    int n_fail = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int m_err = 0;
    int m_ov = 0;
    int n_pairs = 0;
    int cyc = 0;
    int close_cyc = -100;
    int ready_mode = 0;
    bit m_synced = 1'b0;
    bit m_have_left = 1'b0;
    bit prev_valid = 1'b0;
    logic [15:0] m_left = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: applied once per completed slot, from the slot's length and value.
    task automatic model_slot_end(input bit chan, input int len, input logic [31:0] val);
        logic [31:0] sh;
        logic [15:0] word;
        sh   = (len >= 16) ? (val >> (len - 16)) : 32'd0;
        word = sh[15:0];
        if (!m_synced) begin
            m_synced    = 1'b1;
            m_have_left = 1'b0;
        end else if (chan == 1'b0) begin
            if (len < 16) begin
                m_err++;
                m_have_left = 1'b0;
            end else begin
                m_have_left = 1'b1;
                m_left      = word;
            end
        end else begin
            if (m_have_left) begin
                if (len < 16) m_err++;
                else exp_q.push_back({m_left, word});
            end
            m_have_left = 1'b0;
        end
    endtask

    task automatic bck_bit(input logic w, input logic d, input bit closing);
        ADC_I2S_CLK  = 1'b0;
        ADC_I2S_WS   = w;
        ADC_I2S_DATA = d;
        repeat (4) @(posedge MasterCLK);
        #3;
        ADC_I2S_CLK = 1'b1;
        if (closing) close_cyc = cyc;
        repeat (4) @(posedge MasterCLK);
        #3;
    endtask

    task automatic add_slot(input bit chan, input int len, input logic [31:0] val);
        slot_t s;
        s.chan = chan;
        s.len  = len;
        s.val  = val;
        slot_q.push_back(s);
    endtask

    // WS leads data by one bit: the last bit of a slot already carries the next channel.
    task automatic run_slots(input bit next_after);
        for (int s = 0; s < slot_q.size(); s++) begin
            bit ch;
            bit nx;
            int len;
            ch  = slot_q[s].chan;
            len = slot_q[s].len;
            nx  = (s + 1 < slot_q.size()) ? slot_q[s+1].chan : next_after;
            for (int i = 0; i < len; i++) begin
                if (i == len - 1) begin
                    if (nx != ch) model_slot_end(ch, len, slot_q[s].val);
                    bck_bit(nx, slot_q[s].val[len-1-i], ch && !nx);
                end else begin
                    bck_bit(ch, slot_q[s].val[len-1-i], 1'b0);
                end
            end
        end
        slot_q.delete();
    endtask

    task automatic settle(input string tag);
        repeat (16) @(posedge MasterCLK);
        #3;
        check({tag, "_frame_errors"}, 64'(fe_seen), 64'(m_err));
        check({tag, "_overruns"}, 64'(ov_seen), 64'(m_ov));
        if (ready_mode != 0) check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic int rand_len();
        int r;
        r = int'($urandom_range(0, 7));
        return (r == 0) ? 10 : int'($urandom_range(16, 32));
    endfunction

    always @(posedge MasterCLK) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge MasterCLK);
            #2;
            SampleReady = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    // Every rising SampleValid must land 4 clocks after the closing right-LSB BCK edge.
    initial begin
        forever begin
            @(posedge MasterCLK);
            #1;
            if (!Reset && SampleValid && !prev_valid) check("latency", 64'(cyc - close_cyc), 64'd4);
            prev_valid = SampleValid;
        end
    end

    initial begin
        forever begin
            @(negedge MasterCLK);
            if (!Reset) begin
                if (FrameError) fe_seen++;
                if (Overrun) begin
                    ov_seen++;
                    if (exp_q.size() > 0) popped = exp_q.pop_front();
                    $display("overrun: pair displaced, now left=%h right=%h", SampleLeft, SampleRight);
                end
                if (SampleValid && SampleReady) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pair: got %h_%h, expected none", SampleLeft, SampleRight);
                    end else begin
                        popped = exp_q.pop_front();
                        n_pairs++;
                        $display("pair %0d: left=%h right=%h expected=%h", n_pairs, SampleLeft, SampleRight, popped);
                        check("pair", {32'd0, SampleLeft, SampleRight}, {32'd0, popped});
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge MasterCLK);
        #3;
        check("reset_state", {SampleLeft, SampleRight, SampleValid, Overrun, FrameError}, 64'd0);
        Reset      = 1'b0;
        ready_mode = 1;
        repeat (4) @(posedge MasterCLK);
        #3;

        // Start-up partial frame, then two full 32-bit frames.
        add_slot(0, 32, $urandom);
        add_slot(1, 32, $urandom);
        add_slot(0, 32, {16'hA5C3, 16'($urandom)});
        add_slot(1, 32, {16'h1234, 16'($urandom)});
        add_slot(0, 32, {16'h0001, 16'($urandom)});
        add_slot(1, 32, {16'hFFFF, 16'($urandom)});
        run_slots(1'b0);
        settle("startup");

        // Consumer stalled over two frames: second publish displaces the first.
        ready_mode = 0;
        add_slot(0, 32, $urandom);
        add_slot(1, 32, $urandom);
        add_slot(0, 32, $urandom);
        add_slot(1, 32, $urandom);
        run_slots(1'b0);
        m_ov++;
        settle("stalled");
        check("stalled_valid_held", 64'(SampleValid), 64'd1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL stalled_pair: got %h_%h, expected a queued pair", SampleLeft, SampleRight);
        end else begin
            check("stalled_pair", {32'd0, SampleLeft, SampleRight}, {32'd0, exp_q[0]});
        end
        ready_mode = 1;
        settle("released");

        // Truncated left slot, then a full frame.
        add_slot(0, 10, $urandom);
        add_slot(1, 32, $urandom);
        add_slot(0, 32, $urandom);
        add_slot(1, 32, $urandom);
        run_slots(1'b0);
        settle("truncated");

        // Slots of exactly 16 bits.
        add_slot(0, 16, 32'h0000_8000);
        add_slot(1, 16, 32'h0000_0001);
        add_slot(0, 16, {16'd0, 16'($urandom)});
        add_slot(1, 16, {16'd0, 16'($urandom)});
        run_slots(1'b0);
        settle("exact16");

        // Random slot lengths and values with a random consumer.
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            add_slot(0, rand_len(), $urandom);
            add_slot(1, rand_len(), $urandom);
        end
        run_slots(1'b0);
        ready_mode = 1;
        settle("random");

        // Reset in the middle of a right slot.
        add_slot(0, 32, $urandom);
        add_slot(1, 32, $urandom);
        add_slot(0, 32, $urandom);
        run_slots(1'b1);
        for (int i = 0; i < 8; i++) bck_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        Reset = 1'b1;
        #1;
        check("reset_async_outputs", {SampleLeft, SampleRight, SampleValid, Overrun, FrameError}, 64'd0);
        m_synced    = 1'b0;
        m_have_left = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge MasterCLK);
        #3;
        Reset = 1'b0;
        add_slot(1, 24, $urandom);
        add_slot(0, 32, $urandom);
        add_slot(1, 32, $urandom);
        add_slot(0, 20, $urandom);
        add_slot(1, 20, $urandom);
        run_slots(1'b0);
        settle("post_reset");

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
